// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the 4-beat cacheline burst memory responder.
// The read request keeps the full line address so the returned dfp_raddr can be rebuilt.
package burst_mem_pkg;

    localparam int BEAT_W   = 64;
    localparam int LINE_W   = 256;
    localparam int BEATS    = 4;
    localparam int OFFSET_W = 5;
    localparam int ADDR_W   = 32;
    localparam int LADDR_W  = ADDR_W - OFFSET_W;
    localparam int CD_W     = 6;

    typedef logic [1:0] beat_idx_t;

    typedef enum logic {R_IDLE, R_BURST} rstate_t;
    typedef enum logic {W_IDLE, W_BURST} wstate_t;

    typedef struct packed {
        logic [LADDR_W-1:0] line_addr;
        logic [CD_W-1:0]    countdown;
    } rd_req_t;

    localparam int REQ_W = $bits(rd_req_t);

endpackage

// File: rtl/burst_mem_responder_req_fifo.sv
// Outstanding-read queue: a plain synchronous FIFO of rd_req_t whose entries
// count their remaining latency down in place, saturating at zero.
module req_fifo
    import burst_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [REQ_W-1:0] push_data,
    input  logic             pop,
    output logic [REQ_W-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    rd_req_t          entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = entries[rd_ptr];

    // Stale slots also count down; harmless because a push overwrites its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[i].countdown != '0) begin
                    entries[i].countdown <= entries[i].countdown - CD_W'(1);
                end
            end
            if (push_ok) begin
                entries[wr_ptr] <= rd_req_t'(push_data);
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/burst_mem_responder.sv
// DRAM stand-in: accepts 4-beat write bursts and single-cycle read commands,
// returns each read line as 4 beats a fixed latency after the accept edge.
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int LINE_IDX_W = 8,
    parameter int LATENCY    = 6,
    parameter int QDEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dfp_addr,
    input  logic        dfp_read,
    input  logic        dfp_write,
    input  logic [63:0] dfp_wdata,
    output logic        dfp_ready,
    output logic [31:0] dfp_raddr,
    output logic [63:0] dfp_rdata,
    output logic        dfp_rvalid,
    output logic        err
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic [LINE_W-1:0]     mem [2**LINE_IDX_W];

    wstate_t               wstate;
    rstate_t               rstate;
    beat_idx_t             wbeat;
    beat_idx_t             rbeat;
    logic [LINE_IDX_W-1:0] wline;
    logic [LINE_W-1:0]     lbuf;
    logic                  alive;

    rd_req_t               push_req;
    rd_req_t               head;
    logic [REQ_W-1:0]      head_bits;
    logic [CNT_W-1:0]      q_count;
    logic                  q_full;
    logic                  q_empty;

    logic                  read_accept;
    logic                  burst_last;
    logic                  launch;
    logic [LINE_IDX_W-1:0] head_idx;
    logic [LINE_W-1:0]     launch_line;

    logic                  wr_en;
    logic [LINE_IDX_W-1:0] wr_idx;
    beat_idx_t             wr_slice;
    logic [LINE_IDX_W-1:0] cmd_idx;

    logic                  read_dropped;
    logic                  rw_collide;
    logic                  write_gap;
    logic                  unused_bits;

    // alive keeps ready low until the first clock edge after reset release.
    assign dfp_ready   = alive && (q_count < CNT_W'(QDEPTH)) && (wstate == W_IDLE);
    assign read_accept = dfp_read && dfp_ready && !dfp_write;
    assign cmd_idx     = dfp_addr[OFFSET_W +: LINE_IDX_W];
    assign unused_bits = ^{dfp_addr[OFFSET_W-1:0], q_full};

    assign push_req.line_addr = dfp_addr[ADDR_W-1:OFFSET_W];
    assign push_req.countdown = CD_W'(LATENCY - 1);

    req_fifo #(.DEPTH(QDEPTH)) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (read_accept),
        .push_data (push_req),
        .pop       (launch),
        .head      (head_bits),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign head        = rd_req_t'(head_bits);
    assign head_idx    = head.line_addr[LINE_IDX_W-1:0];
    assign launch_line = mem[head_idx];
    assign burst_last  = (rstate == R_BURST) && (rbeat == beat_idx_t'(BEATS - 1));
    assign launch      = !q_empty && (head.countdown == '0) && ((rstate == R_IDLE) || burst_last);

    assign read_dropped = dfp_read && !dfp_ready;
    assign rw_collide   = dfp_read && dfp_write && dfp_ready;
    assign write_gap    = (wstate == W_BURST) && !dfp_write;

    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = cmd_idx;
        wr_slice = '0;
        if (wstate == W_IDLE) begin
            wr_en = dfp_write && dfp_ready;
        end else begin
            wr_en    = dfp_write;
            wr_idx   = wline;
            wr_slice = wbeat;
        end
    end

    // Each beat lands in its slice on its own edge, so an aborted burst leaves
    // the earlier slices updated.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx][BEAT_W*wr_slice +: BEAT_W] <= dfp_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate <= W_IDLE;
            wbeat  <= '0;
            wline  <= '0;
            err    <= 1'b0;
            alive  <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (read_dropped || rw_collide || write_gap) begin
                err <= 1'b1;
            end
            if (wstate == W_IDLE) begin
                if (dfp_write && dfp_ready) begin
                    wline  <= cmd_idx;
                    wbeat  <= beat_idx_t'(1);
                    wstate <= W_BURST;
                end
            end else begin
                if (!dfp_write || (wbeat == beat_idx_t'(BEATS - 1))) begin
                    wstate <= W_IDLE;
                end else begin
                    wbeat <= wbeat + beat_idx_t'(1);
                end
            end
        end
    end

    // The whole line is captured at launch; lbuf then shifts one beat per cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate     <= R_IDLE;
            rbeat      <= '0;
            lbuf       <= '0;
            dfp_rdata  <= '0;
            dfp_raddr  <= '0;
            dfp_rvalid <= 1'b0;
        end else begin
            if (launch) begin
                rstate     <= R_BURST;
                rbeat      <= '0;
                lbuf       <= launch_line;
                dfp_rdata  <= launch_line[BEAT_W-1:0];
                dfp_raddr  <= {head.line_addr, {OFFSET_W{1'b0}}};
                dfp_rvalid <= 1'b1;
            end else if (rstate == R_BURST) begin
                if (burst_last) begin
                    rstate     <= R_IDLE;
                    dfp_rvalid <= 1'b0;
                end else begin
                    rbeat     <= rbeat + beat_idx_t'(1);
                    dfp_rdata <= lbuf[2*BEAT_W-1:BEAT_W];
                    lbuf      <= lbuf >> BEAT_W;
                end
            end
        end
    end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Bench for burst_mem_responder: vector table, hand-built corner sequences and a
// random phase checked against a timing/memory model derived from the protocol rules.
module tb_burst_mem_responder;

    localparam int LINE_IDX_W = 8;
    localparam int LATENCY    = 6;
    localparam int QDEPTH     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] dfp_addr = '0;
    logic        dfp_read = 1'b0;
    logic        dfp_write = 1'b0;
    logic [63:0] dfp_wdata = '0;
    logic        dfp_ready;
    logic [31:0] dfp_raddr;
    logic [63:0] dfp_rdata;
    logic        dfp_rvalid;
    logic        err;

    burst_mem_responder #(
        .LINE_IDX_W (LINE_IDX_W),
        .LATENCY    (LATENCY),
        .QDEPTH     (QDEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dfp_addr   (dfp_addr),
        .dfp_read   (dfp_read),
        .dfp_write  (dfp_write),
        .dfp_wdata  (dfp_wdata),
        .dfp_ready  (dfp_ready),
        .dfp_raddr  (dfp_raddr),
        .dfp_rdata  (dfp_rdata),
        .dfp_rvalid (dfp_rvalid),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edge_n;
        logic [31:0] raddr;
        logic [63:0] data;
    } beat_t;

    typedef struct {
        logic [31:0]       waddr;
        logic [3:0][63:0]  wbeat;
        logic [31:0]       rdaddr;
        logic [31:0]       exp_raddr;
        logic [3:0][63:0]  exp_beat;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          drive_edge = 0;
    beat_t       obs_q[$];
    beat_t       exp_q[$];
    logic [255:0] mdl_mem [256];
    vec_t        vecs [4];

    // Edge counter plus a record of every returned beat, sampled 1 unit after the edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (dfp_rvalid === 1'b1) begin
                obs_q.push_back('{edge_n: cyc, raddr: dfp_raddr, data: dfp_rdata});
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr, input logic [63:0] wdata);
        @(negedge clk);
        dfp_read   = rd;
        dfp_write  = wr;
        dfp_addr   = addr;
        dfp_wdata  = wdata;
        drive_edge = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 32'h0, 64'h0);
    endtask

    task automatic waitBeats(input int n, input int budget);
        int b = 0;
        while (obs_q.size() < n && b < budget) begin
            @(posedge clk);
            #2;
            b++;
        end
        checks++;
        if (obs_q.size() < n) begin
            errors++;
            $display("[TB] FAIL beat_timeout: got %0d beats expected %0d", obs_q.size(), n);
        end
    endtask

    // gap_beat stops the burst at that beat; read_beat raises dfp_read alongside that beat.
    task automatic writeBurst(input logic [31:0] addr, input logic [3:0][63:0] beats,
                              input int gap_beat, input int read_beat);
        for (int k = 0; k < 4; k++) begin
            if (k == gap_beat) begin
                applyStimulus(1'b0, 1'b0, addr, 64'h0);
                break;
            end
            applyStimulus(k == read_beat, 1'b1, addr, beats[k]);
            mdl_mem[addr[12:5]][64*k +: 64] = beats[k];
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 64'h0);
    endtask

    task automatic readLine(input string name, input logic [31:0] addr, input logic [31:0] exp_raddr,
                            input logic [3:0][63:0] exp_beats);
        int acc;
        obs_q.delete();
        applyStimulus(1'b1, 1'b0, addr, 64'h0);
        acc = drive_edge;
        checkOutput({name, "_ready"}, 64'(dfp_ready), 64'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 64'h0);
        waitBeats(4, LATENCY + 12);
        idle(6);
        checkOutput({name, "_count"}, 64'(obs_q.size()), 64'd4);
        for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
            checkOutput({name, "_edge"}, 64'(obs_q[k].edge_n), 64'(acc + LATENCY + k));
            checkOutput({name, "_raddr"}, 64'(obs_q[k].raddr), 64'(exp_raddr));
            checkOutput({name, "_data"}, obs_q[k].data, exp_beats[k]);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        dfp_read = 1'b0;
        dfp_write = 1'b0;
        #1;
        checkOutput("rst_rvalid", 64'(dfp_rvalid), 64'h0);
        checkOutput("rst_err", 64'(err), 64'h0);
        checkOutput("rst_ready", 64'(dfp_ready), 64'h0);
        checkOutput("rst_rdata", dfp_rdata, 64'h0);
        checkOutput("rst_raddr", 64'(dfp_raddr), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_after_release", 64'(dfp_ready), 64'h1);
    endtask

    initial begin
        int          acc0;
        int          last_l;
        int          pend_l[$];
        logic [31:0] rnd;
        logic [7:0]  line;
        logic [3:0][63:0] beats;

        vecs[0] = '{32'h0000_1040, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    32'h0000_1044, 32'h0000_1040,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
        vecs[1] = '{32'h0000_1FE0, {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
                                    64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000},
                    32'h0000_1FFF, 32'h0000_1FE0,
                    {64'hDEAD_BEEF_0000_0003, 64'hDEAD_BEEF_0000_0002,
                     64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0000}};
        vecs[2] = '{32'hABCD_0020, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                    64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_F0F0_0F0F_F0F0},
                    32'hABCD_003C, 32'hABCD_0020,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                     64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_F0F0_0F0F_F0F0}};
        // Line index only uses addr[12:5], so 0x2040 and 0x0048 alias the same line.
        vecs[3] = '{32'h0000_2040, {64'h8000_0000_0000_0004, 64'h8000_0000_0000_0003,
                                    64'h8000_0000_0000_0002, 64'h8000_0000_0000_0001},
                    32'h0000_0048, 32'h0000_0040,
                    {64'h8000_0000_0000_0004, 64'h8000_0000_0000_0003,
                     64'h8000_0000_0000_0002, 64'h8000_0000_0000_0001}};

        doReset();

        for (int v = 0; v < 4; v++) begin
            writeBurst(vecs[v].waddr, vecs[v].wbeat, -1, -1);
            readLine($sformatf("vec%0d", v), vecs[v].rdaddr, vecs[v].exp_raddr, vecs[v].exp_beat);
        end
        checkOutput("vec_no_err", 64'(err), 64'h0);

        $display("[TB] back-to-back reads and queue-full drop");
        for (int i = 0; i < 4; i++) begin
            beats = {64'(32'hB2B0_0030 + i), 64'(32'hB2B0_0020 + i), 64'(32'hB2B0_0010 + i), 64'(32'hB2B0_0000 + i)};
            writeBurst(32'(i * 32), beats, -1, -1);
        end
        obs_q.delete();
        applyStimulus(1'b1, 1'b0, 32'h0000_0000, 64'h0);
        acc0 = drive_edge;
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'(i * 32), 64'h0);
        end
        applyStimulus(1'b1, 1'b0, 32'h0000_0080, 64'h0);
        checkOutput("ready_when_full", 64'(dfp_ready), 64'h0);
        checkOutput("b2b_no_err", 64'(err), 64'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 64'h0);
        checkOutput("full_drop_err", 64'(err), 64'h1);
        waitBeats(16, 60);
        idle(8);
        checkOutput("b2b_count", 64'(obs_q.size()), 64'd16);
        for (int j = 0; j < 16 && j < obs_q.size(); j++) begin
            checkOutput("b2b_edge", 64'(obs_q[j].edge_n), 64'(acc0 + LATENCY + j));
            checkOutput("b2b_raddr", 64'(obs_q[j].raddr), 64'((j / 4) * 32));
            checkOutput("b2b_data", obs_q[j].data, mdl_mem[j / 4][64*(j % 4) +: 64]);
        end
        doReset();

        $display("[TB] read during write burst");
        writeBurst(32'h0000_0300, {64'hC3, 64'hC2, 64'hC1, 64'hC0}, -1, 2);
        checkOutput("rd_in_wburst_err", 64'(err), 64'h1);
        readLine("rd_in_wburst", 32'h0000_0300, 32'h0000_0300, mdl_mem[8'h18]);
        doReset();

        $display("[TB] simultaneous read and write");
        writeBurst(32'h0000_0320, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, -1, 0);
        checkOutput("rw_collide_err", 64'(err), 64'h1);
        readLine("rw_collide", 32'h0000_0320, 32'h0000_0320, mdl_mem[8'h19]);
        doReset();

        $display("[TB] write burst gap");
        writeBurst(32'h0000_0340, {64'hE3, 64'hE2, 64'hE1, 64'hE0}, -1, -1);
        checkOutput("pre_gap_no_err", 64'(err), 64'h0);
        writeBurst(32'h0000_0340, {64'hF3, 64'hF2, 64'hF1, 64'hF0}, 2, -1);
        checkOutput("gap_err", 64'(err), 64'h1);
        checkOutput("gap_back_idle", 64'(dfp_ready), 64'h1);
        readLine("gap", 32'h0000_0340, 32'h0000_0340, {64'hE3, 64'hE2, 64'hF1, 64'hF0});
        doReset();

        $display("[TB] reset during read burst");
        writeBurst(32'h0000_00A0, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, -1, -1);
        writeBurst(32'h0000_00C0, {64'hC3C3, 64'hC2C2, 64'hC1C1, 64'hC0C0}, -1, -1);
        obs_q.delete();
        applyStimulus(1'b1, 1'b0, 32'h0000_00A0, 64'h0);
        applyStimulus(1'b1, 1'b0, 32'h0000_00C0, 64'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 64'h0);
        waitBeats(2, 30);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_rvalid", 64'(dfp_rvalid), 64'h0);
        checkOutput("rst_mid_err", 64'(err), 64'h0);
        checkOutput("rst_mid_ready", 64'(dfp_ready), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_ready_release", 64'(dfp_ready), 64'h1);
        obs_q.delete();
        idle(14);
        checkOutput("rst_mid_flushed", 64'(obs_q.size()), 64'd0);
        readLine("post_reset", 32'h0000_00C4, 32'h0000_00C0, mdl_mem[8'h06]);

        $display("[TB] random phase");
        for (int i = 0; i < 8; i++) begin
            beats = {64'({$urandom(), $urandom()}), 64'({$urandom(), $urandom()}),
                     64'({$urandom(), $urandom()}), 64'({$urandom(), $urandom()})};
            writeBurst(32'(32'h0000_0200 + i * 32), beats, -1, -1);
        end
        pend_l.delete();
        exp_q.delete();
        obs_q.delete();
        last_l = -1000;
        for (int op = 0; op < 150; op++) begin
            int t;
            int r;
            @(negedge clk);
            t = cyc + 1;
            while (pend_l.size() > 0 && pend_l[0] < t) void'(pend_l.pop_front());
            checkOutput("rand_ready", 64'(dfp_ready), 64'(pend_l.size() < QDEPTH));
            r = $urandom_range(0, 9);
            rnd = $urandom();
            line = 8'h10 + 8'($urandom_range(0, 7));
            if (r < 5 && pend_l.size() < QDEPTH) begin
                int l;
                dfp_read  = 1'b1;
                dfp_write = 1'b0;
                dfp_addr  = {rnd[31:13], line, rnd[4:0]};
                l = (t + LATENCY > last_l + 4) ? t + LATENCY : last_l + 4;
                last_l = l;
                pend_l.push_back(l);
                for (int k = 0; k < 4; k++) begin
                    exp_q.push_back('{edge_n: l + k, raddr: {rnd[31:13], line, 5'b0},
                                      data: mdl_mem[line][64*k +: 64]});
                end
            end else if (r < 7 && pend_l.size() == 0) begin
                dfp_read  = 1'b0;
                dfp_write = 1'b1;
                dfp_addr  = {rnd[31:13], line, rnd[4:0]};
                for (int k = 0; k < 4; k++) begin
                    if (k > 0) begin
                        @(negedge clk);
                        checkOutput("rand_ready_wburst", 64'(dfp_ready), 64'h0);
                    end
                    dfp_wdata = {$urandom(), $urandom()};
                    mdl_mem[line][64*k +: 64] = dfp_wdata;
                end
            end else begin
                dfp_read  = 1'b0;
                dfp_write = 1'b0;
            end
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 64'h0);
        waitBeats(exp_q.size(), 200);
        idle(8);
        checkOutput("rand_count", 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checkOutput("rand_edge", 64'(obs_q[i].edge_n), 64'(exp_q[i].edge_n));
            checkOutput("rand_raddr", 64'(obs_q[i].raddr), 64'(exp_q[i].raddr));
            checkOutput("rand_data", obs_q[i].data, exp_q[i].data);
        end
        checkOutput("rand_no_err", 64'(err), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
